// File: rtl/socriscv_bus_pkg.sv
// Shared bus types for the RAM arbiter: master ids, FSM states, read tag.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package socriscv_bus_pkg;

  localparam logic M_CORE = 1'b0;
  localparam logic M_AUX  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Ownership state that corresponds to a granted master id.
  function automatic arb_state_e own_state(input logic id);
    return id ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/ram_arbiter2_if.sv
// Read-tag link between the arbiter issue stage and the tag pipe.
// Latency: wires only.
// Backpressure: none; a tag is pushed every cycle (invalid when no read).
// Ports: push_tag (arbiter -> pipe), tail_tag (pipe -> arbiter).
interface ram_arbiter2_if;
  import socriscv_bus_pkg::*;

  rd_tag_t push_tag;
  rd_tag_t tail_tag;

  modport arb  (output push_tag, input  tail_tag);
  modport pipe (input  push_tag, output tail_tag);
endinterface

// File: rtl/rd_tag_pipe.sv
// Shift pipe carrying {valid, id} read tags alongside the RAM read latency.
// Latency: DEPTH cycles from push_tag to tail_tag.
// Backpressure: none; shifts every cycle, async clear drops all tags.
// Ports: iCLK, iRST (active-low async clear), tag_if (pipe modport).
module rd_tag_pipe
  import socriscv_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  ram_arbiter2_if.pipe    tag_if
);

  rd_tag_t pipe_q [DEPTH];
  rd_tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_if.push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_if.tail_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter2.sv
// Two-master arbiter for a single-port RAM with registered strobes and tagged read return.
// Latency: grant combinational; strobes +1 cycle; read VALID +1+RD_LAT cycles after grant.
// Backpressure: a master holds REQ until GNT; the owner is pre-empted after MAX_HOLD grants under contention.
// Ports: iCLK/iRST, per-master REQ/WR/ADDR/DATA in and GNT/VALID/DATA out,
//        registered oRAM_CE/RD/WR/ADDR/DATA, iRAM_DATA, oOWNER (id of last grant).
module ram_arbiter2
  import socriscv_bus_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iM0_REQ,
  input  logic          iM0_WR,
  input  logic [AW-1:0] iM0_ADDR,
  input  logic [DW-1:0] iM0_DATA,
  output logic          oM0_GNT,
  output logic          oM0_VALID,
  output logic [DW-1:0] oM0_DATA,
  input  logic          iM1_REQ,
  input  logic          iM1_WR,
  input  logic [AW-1:0] iM1_ADDR,
  input  logic [DW-1:0] iM1_DATA,
  output logic          oM1_GNT,
  output logic          oM1_VALID,
  output logic [DW-1:0] oM1_DATA,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [DW-1:0] oRAM_DATA,
  input  logic [DW-1:0] iRAM_DATA,
  output logic          oOWNER
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [7:0]    hold_q, hold_d;
  logic          ce_q, ce_d, rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          owner_q, owner_d;

  logic          any_req;
  logic          win;

  // Winner selection. With both requesting, the owner keeps the bus until
  // its hold budget is used up; from IDLE the master that did not go last wins.
  always_comb begin
    any_req = iM0_REQ | iM1_REQ;
    win     = iM1_REQ;
    if (iM0_REQ && iM1_REQ) begin
      case (state_q)
        ARB_OWN0: win = (hold_q < HOLD_LIM) ? M_CORE : M_AUX;
        ARB_OWN1: win = (hold_q < HOLD_LIM) ? M_AUX : M_CORE;
        default:  win = ~last_q;
      endcase
    end
  end

  assign oM0_GNT = any_req & (win == M_CORE);
  assign oM1_GNT = any_req & (win == M_AUX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    ce_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    owner_d = owner_q;
    if (any_req) begin
      if (state_q == own_state(win)) begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      end else begin
        state_d = own_state(win);
        hold_d  = 8'd1;
        last_d  = win;
      end
      ce_d    = 1'b1;
      wr_d    = win ? iM1_WR : iM0_WR;
      rd_d    = ~wr_d;
      addr_d  = win ? iM1_ADDR : iM0_ADDR;
      data_d  = win ? iM1_DATA : iM0_DATA;
      owner_d = win;
    end else begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ARB_IDLE;
      last_q  <= M_AUX;
      hold_q  <= 8'd0;
      ce_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      ce_q    <= ce_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
    end
  end

  assign oRAM_CE   = ce_q;
  assign oRAM_RD   = rd_q;
  assign oRAM_WR   = wr_q;
  assign oRAM_ADDR = addr_q;
  assign oRAM_DATA = data_q;
  assign oOWNER    = owner_q;

  // The tag enters the pipe from the registered strobe stage, so it lines up
  // with RAM data that appears RD_LAT cycles after oRAM_RD.
  ram_arbiter2_if tag_if ();

  assign tag_if.push_tag = '{valid: rd_q, id: owner_q};

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .tag_if (tag_if.pipe)
  );

  assign oM0_VALID = tag_if.tail_tag.valid & (tag_if.tail_tag.id == M_CORE);
  assign oM1_VALID = tag_if.tail_tag.valid & (tag_if.tail_tag.id == M_AUX);
  assign oM0_DATA  = iRAM_DATA;
  assign oM1_DATA  = iRAM_DATA;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed bench for ram_arbiter2 (RD_LAT=1, MAX_HOLD=4) with a behavioural 1-cycle RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdat = '0, m1_addr = '0, m1_wdat = '0;
  logic        m0_gnt, m0_vld, m1_gnt, m1_vld;
  logic [31:0] m0_rdat, m1_rdat;
  logic        ram_ce, ram_rd, ram_wr, owner;
  logic [31:0] ram_addr, ram_wdat, ram_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter2 #(.AW(32), .DW(32), .RD_LAT(1), .MAX_HOLD(4)) dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iM0_REQ   (m0_req),
    .iM0_WR    (m0_wr),
    .iM0_ADDR  (m0_addr),
    .iM0_DATA  (m0_wdat),
    .oM0_GNT   (m0_gnt),
    .oM0_VALID (m0_vld),
    .oM0_DATA  (m0_rdat),
    .iM1_REQ   (m1_req),
    .iM1_WR    (m1_wr),
    .iM1_ADDR  (m1_addr),
    .iM1_DATA  (m1_wdat),
    .oM1_GNT   (m1_gnt),
    .oM1_VALID (m1_vld),
    .oM1_DATA  (m1_rdat),
    .oRAM_CE   (ram_ce),
    .oRAM_RD   (ram_rd),
    .oRAM_WR   (ram_wr),
    .oRAM_ADDR (ram_addr),
    .oRAM_DATA (ram_wdat),
    .iRAM_DATA (ram_dat),
    .oOWNER    (owner)
  );

  // RAM model: default contents A5000000+index, a few preloaded words.
  logic [31:0] mem [1024];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      mem[10'h100] <= 32'hDEAD_BEEF;
      mem[10'h104] <= 32'h1111_2222;
      ram_dat      <= '0;
      init_done    <= 1'b1;
    end else begin
      if (ram_wr) mem[ram_addr[9:0]] <= ram_wdat;
      if (ram_rd) ram_dat <= mem[ram_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int          exp_m [20];
  logic [31:0] exp_a [20];
  int          k0, k1, em;

  initial begin
    // ---- reset state ----
    tick();
    tick();
    #1;
    chk("rst_strobes", {29'd0, ram_ce, ram_rd, ram_wr}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wdata", ram_wdat, 32'd0);
    chk("rst_owner_vld_gnt", {27'd0, owner, m0_vld, m1_vld, m0_gnt, m1_gnt}, 32'd0);
    rst_n = 1'b1;

    // ---- single read by M0 ----
    tick();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h100;
    #1;
    chk("rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    tick();
    m0_req = 1'b0; m0_addr = 32'h3FC;
    #1;
    chk("rd_strobes", {29'd0, ram_ce, ram_rd, ram_wr}, 32'b110);
    chk("rd_addr", ram_addr, 32'h100);
    chk("rd_owner", {31'd0, owner}, 32'd0);
    chk("rd_early_vld", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    #1;
    chk("rd_vld", {30'd0, m1_vld, m0_vld}, 32'd1);
    chk("rd_data", m0_rdat, 32'hDEAD_BEEF);
    tick();
    #1;
    chk("rd_vld_gone", {30'd0, m1_vld, m0_vld}, 32'd0);

    // ---- first tie after reset ----
    do_reset();
    tick();
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h104;
    #1;
    chk("tie_gnt0", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    tick();
    m0_req = 1'b0;
    #1;
    chk("tie_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    chk("tie_addr0", ram_addr, 32'h100);
    tick();
    m1_req = 1'b0;
    #1;
    chk("tie_owner1", {31'd0, owner}, 32'd1);
    chk("tie_addr1", ram_addr, 32'h104);
    chk("tie_vld0", {30'd0, m1_vld, m0_vld}, 32'b01);
    chk("tie_dat0", m0_rdat, 32'hDEAD_BEEF);
    tick();
    #1;
    chk("tie_vld1", {30'd0, m1_vld, m0_vld}, 32'b10);
    chk("tie_dat1", m1_rdat, 32'h1111_2222);

    // ---- streaming contention, MAX_HOLD=4: runs of 4 ----
    tick();
    tick();
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 18; c++) begin
      tick();
      m0_req  = (c < 16);
      m1_req  = (c < 16);
      m0_wr   = 1'b0;
      m1_wr   = 1'b0;
      m0_addr = 32'h200 + 32'(4 * k0);
      m1_addr = 32'h300 + 32'(4 * k1);
      #1;
      if (c < 16) begin
        em = (c / 4) % 2;
        chk($sformatf("str_gnt_c%0d", c), {30'd0, m1_gnt, m0_gnt}, (em == 1) ? 32'b10 : 32'b01);
        exp_m[c] = em;
        exp_a[c] = (em == 1) ? m1_addr : m0_addr;
        if (em == 1) k1++;
        else k0++;
      end
      if (c >= 2) begin
        chk($sformatf("str_vld_c%0d", c), {30'd0, m1_vld, m0_vld},
            (exp_m[c-2] == 1) ? 32'b10 : 32'b01);
        chk($sformatf("str_dat_c%0d", c), (exp_m[c-2] == 1) ? m1_rdat : m0_rdat,
            32'hA500_0000 + exp_a[c-2]);
      end
    end

    // ---- M1 write then M0 read ----
    tick();
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h20; m1_wdat = 32'hCAFE_0001;
    #1;
    chk("wr_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    tick();
    m1_req = 1'b0; m1_wdat = 32'h0;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h20;
    #1;
    chk("wr_gnt0", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    chk("wr_strobes", {29'd0, ram_ce, ram_rd, ram_wr}, 32'b101);
    chk("wr_addr", ram_addr, 32'h20);
    chk("wr_data", ram_wdat, 32'hCAFE_0001);
    tick();
    m0_req = 1'b0;
    #1;
    chk("wr_rd_strobes", {29'd0, ram_ce, ram_rd, ram_wr}, 32'b110);
    chk("wr_no_vld", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    #1;
    chk("wr_rb_vld", {30'd0, m1_vld, m0_vld}, 32'b01);
    chk("wr_rb_dat", m0_rdat, 32'hCAFE_0001);

    // ---- reset in the middle of a read ----
    tick();
    m0_req = 1'b1; m0_addr = 32'h100;
    #1;
    chk("mr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    tick();
    m0_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mr_strobes", {29'd0, ram_ce, ram_rd, ram_wr}, 32'd0);
    chk("mr_vld_a", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    #1;
    chk("mr_vld_b", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    #1;
    chk("mr_vld_c", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_vld_d", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    #1;
    chk("mr_vld_e", {30'd0, m1_vld, m0_vld}, 32'd0);
    tick();
    m0_req = 1'b1; m1_req = 1'b1; m1_wr = 1'b0;
    #1;
    chk("mr_tie", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
